// File: rtl/serial_mag_comp_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_mag_comp_ctrl_if                                         |
// | Purpose  : Request/result bundle for the serial magnitude comparator.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface serial_mag_comp_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH / 2) + 1
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             greater;
  logic             equal;
  logic             less;
  logic [CW-1:0]    slices;

  modport master (
    output start, a, b,
    input  busy, done, greater, equal, less, slices
  );

  modport slave (
    input  start, a, b,
    output busy, done, greater, equal, less, slices
  );
endinterface
`default_nettype wire

// File: rtl/serial_mag_comp_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_mag_comp_ctrl                                            |
// | Purpose  : MSB-first multi-cycle magnitude compare, one 2-bit slice/cycle. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

module serial_mag_comp_ctrl_slice2 (
  input  wire logic       en,
  input  wire logic [1:0] a,
  input  wire logic [1:0] b,
  output logic            gt,
  output logic            eq,
  output logic            lt
);
  assign gt = en & (a > b);
  assign eq = en & (a == b);
  assign lt = en & (a < b);
endmodule

module serial_mag_comp_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH / 2) + 1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  serial_mag_comp_ctrl_if.slave  bus
);
  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0]    c_idle = 1'b0;
  localparam logic [0:0]    c_comp = 1'b1;
  localparam logic [IW-1:0] c_last = IW'(N - 1);
  localparam logic [CW-1:0] c_n    = CW'(N);

  logic [0:0]          r_state;
  logic [N-1:0][1:0]   r_a;
  logic [N-1:0][1:0]   r_b;
  logic [IW-1:0]       r_idx;
  logic                r_done;
  logic                r_greater;
  logic                r_equal;
  logic                r_less;
  logic [CW-1:0]       r_slices;

  logic                w_gt;
  logic                w_eq;
  logic                w_lt;
  logic                w_finish;

  serial_mag_comp_ctrl_slice2 u_slice (
    .en (r_state == c_comp),
    .a  (r_a[r_idx]),
    .b  (r_b[r_idx]),
    .gt (w_gt),
    .eq (w_eq),
    .lt (w_lt)
  );

  // An unequal slice settles the answer; reaching slice 0 settles it too.
  assign w_finish = w_gt | w_lt | (r_idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_idle;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_greater <= 1'b0;
      r_equal   <= 1'b0;
      r_less    <= 1'b0;
      r_slices  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_idx   <= c_last;
            r_state <= c_comp;
          end
        end
        c_comp: begin
          if (w_finish) begin
            r_greater <= w_gt;
            r_equal   <= w_eq;
            r_less    <= w_lt;
            r_slices  <= c_n - CW'(r_idx);
            r_done    <= 1'b1;
            r_state   <= c_idle;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign bus.busy    = (r_state == c_comp);
  assign bus.done    = r_done;
  assign bus.greater = r_greater;
  assign bus.equal   = r_equal;
  assign bus.less    = r_less;
  assign bus.slices  = r_slices;
endmodule
`default_nettype wire
